// File: rtl/rr_stream_mux_pkg.sv
// Shared types for rr_stream_mux: stage state, mode encodings, parameter limits.
// Also holds the index-wrap helper used by the arbiter and the pointer update.
package rr_stream_mux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_e;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  localparam int NUM_CH_MIN = 2;
  localparam int NUM_CH_MAX = 16;
  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 64;

  // Operands never exceed 2*n-1, so one conditional subtract is enough.
  function automatic int wrap_idx(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// rr_arbiter: combinational round-robin search, first request at or after i_ptr, wrapping.
// Zero latency; o_any low and o_gnt zero when no request is present.
module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SELW   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [SELW-1:0]   i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [SELW-1:0]   o_idx,
  output logic              o_any
);

  int            w_pos;
  logic [SELW-1:0] w_c;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = 0;
    w_c   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pos = wrap_idx(int'(i_ptr) + i, NUM_CH);
      w_c   = w_pos[SELW-1:0];
      if (!o_any && i_req[w_c]) begin
        o_any      = 1'b1;
        o_idx      = w_c;
        o_gnt[w_c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 stream mux (fixed select or round-robin) into a one-entry output register; 1-cycle latency,
// drains and refills in the same cycle; optional packet lock under RR_MUX_PKT_LOCK_EN.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 8,
  localparam int SELW   = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode,
  input  logic [SELW-1:0]              sel,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH-1:0][WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [SELW-1:0]              out_ch,
  input  logic                         out_ready
`ifdef RR_MUX_PKT_LOCK_EN
  ,
  input  logic [NUM_CH-1:0]            in_last,
  output logic                         out_last
`endif
);

  stage_e            r_state;
  stage_e            w_state_nxt;
  logic [WIDTH-1:0]  r_data;
  logic [SELW-1:0]   r_ch;
  logic [SELW-1:0]   r_ptr;
  logic [SELW-1:0]   w_rr_idx;
  logic [SELW-1:0]   w_gnt_idx;
  logic [NUM_CH-1:0] w_rr_gnt;
  logic [NUM_CH-1:0] w_gnt_oh;
  logic              w_rr_any;
  logic              w_load_ok;
  logic              w_take;

`ifdef RR_MUX_PKT_LOCK_EN
  logic              r_locked;
  logic [SELW-1:0]   r_lock_ch;
  logic              r_last;
`endif

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SELW   (SELW)
  ) u_arb (
    .i_req  (in_valid),
    .i_ptr  (r_ptr),
    .o_gnt  (w_rr_gnt),
    .o_idx  (w_rr_idx),
    .o_any  (w_rr_any)
  );

  // An open packet owns the grant until its last beat transfers.
  always_comb begin
    w_gnt_oh  = '0;
    w_gnt_idx = '0;
`ifdef RR_MUX_PKT_LOCK_EN
    if (r_locked) begin
      w_gnt_oh[r_lock_ch] = 1'b1;
      w_gnt_idx           = r_lock_ch;
    end else
`endif
    if (mode == MODE_RR) begin
      if (w_rr_any) begin
        w_gnt_oh  = w_rr_gnt;
        w_gnt_idx = w_rr_idx;
      end
    end else if (int'(sel) < NUM_CH) begin
      w_gnt_oh[sel] = 1'b1;
      w_gnt_idx     = sel;
    end
  end

  assign w_load_ok = (r_state == EMPTY) || out_ready;
  assign in_ready  = (rst_n && w_load_ok) ? (w_gnt_oh & in_valid) : '0;
  assign w_take    = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_take)         w_state_nxt = FULL;
    else if (out_ready) w_state_nxt = EMPTY;
  end

  always_comb begin
    out_valid = (r_state == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_ch   <= '0;
      r_ptr  <= '0;
    end else if (w_take) begin
      r_data <= in_data[w_gnt_idx];
      r_ch   <= w_gnt_idx;
      if (mode == MODE_RR) r_ptr <= SELW'(wrap_idx(int'(w_gnt_idx) + 1, NUM_CH));
    end
  end

  assign out_data = r_data;
  assign out_ch   = r_ch;

`ifdef RR_MUX_PKT_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked  <= 1'b0;
      r_lock_ch <= '0;
      r_last    <= 1'b0;
    end else if (w_take) begin
      r_locked  <= !in_last[w_gnt_idx];
      r_lock_ch <= w_gnt_idx;
      r_last    <= in_last[w_gnt_idx];
    end
  end

  assign out_last = r_last;
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: directed literal checks plus randomized traffic against a
// per-cycle behavioural model of the grant rules and the one-entry output stage.
module tb_rr_stream_mux;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 mode;
  logic [SW-1:0]        sel;
  logic [N-1:0]         in_valid;
  logic [N-1:0][W-1:0]  in_data;
  logic [N-1:0]         in_ready;
  logic                 out_valid;
  logic [W-1:0]         out_data;
  logic [SW-1:0]        out_ch;
  logic                 out_ready;
`ifdef RR_MUX_PKT_LOCK_EN
  logic [N-1:0]         in_last;
  logic                 out_last;
`endif

  rr_stream_mux #(.NUM_CH(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
`ifdef RR_MUX_PKT_LOCK_EN
    ,
    .in_last   (in_last),
    .out_last  (out_last)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the output stage holds and where round-robin resumes.
  bit          m_full;
  logic [W-1:0] m_data;
  int          m_ch;
  int          m_ptr;
  bit          m_locked;
  int          m_lock_ch;
  bit          m_last;
  int          m_g;

  // Channel that transfers this cycle, or -1.
  function automatic int mgrant();
    int g = -1;
    if (!rst_n) return -1;
    if (m_full && !out_ready) return -1;
    if (m_locked) g = m_lock_ch;
    else if (mode) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g < 0 && in_valid[SW'(c)]) g = c;
      end
    end else if (int'(sel) < N) g = int'(sel);
    if (g >= 0 && !in_valid[SW'(g)]) g = -1;
    return g;
  endfunction

  function automatic logic [N-1:0] exp_rdy(input int g);
    logic [N-1:0] r = '0;
    if (g >= 0) r[SW'(g)] = 1'b1;
    return r;
  endfunction

  always_comb m_g = mgrant();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full    <= 1'b0;
      m_data    <= '0;
      m_ch      <= 0;
      m_ptr     <= 0;
      m_locked  <= 1'b0;
      m_lock_ch <= 0;
      m_last    <= 1'b0;
    end else if (m_g >= 0) begin
      m_full <= 1'b1;
      m_data <= in_data[SW'(m_g)];
      m_ch   <= m_g;
      if (mode) m_ptr <= (m_g + 1) % N;
`ifdef RR_MUX_PKT_LOCK_EN
      m_last    <= in_last[SW'(m_g)];
      m_locked  <= !in_last[SW'(m_g)];
      m_lock_ch <= m_g;
`endif
    end else if (out_ready) begin
      m_full <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_in_ready", 32'(in_ready), 32'(exp_rdy(m_g)));
      chk("m_out_valid", 32'(out_valid), 32'(m_full));
      if (m_full) begin
        chk("m_out_data", 32'(out_data), 32'(m_data));
        chk("m_out_ch", 32'(out_ch), 32'(m_ch));
`ifdef RR_MUX_PKT_LOCK_EN
        chk("m_out_last", 32'(out_last), 32'(m_last));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  int seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef RR_MUX_PKT_LOCK_EN
    in_last   = '0;
`endif
    cmp_en = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    rst_n = 1'b1;
    tick();

    // Fixed select of channel 2.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data[2] = 8'hA5; out_ready = 1'b1;
    #1;
    chk("sel2_in_ready", 32'(in_ready), 32'h4);
    tick();
    chk("sel2_out_valid", 32'(out_valid), 32'd1);
    chk("sel2_out_data", 32'(out_data), 32'hA5);
    chk("sel2_out_ch", 32'(out_ch), 32'd2);
    in_valid = '0;
    tick();

    // Round-robin over four always-valid channels.
    mode = 1'b1; in_valid = 4'hF;
    for (int i = 0; i < N; i++) in_data[i] = W'(8'h10 + i);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_seq_out_ch", 32'(out_ch), 32'(seq[i]));
    end

    // Backpressure holds the beat, then same-cycle drain and refill.
    out_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_ch", 32'(out_ch), 32'd0);
      chk("bp_out_data", 32'(out_data), 32'h10);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'h2);
    tick();
    chk("bp_refill_out_ch", 32'(out_ch), 32'd1);
    chk("bp_refill_out_data", 32'(out_data), 32'h11);

    // Wrap: ptr=2 with only ch3 and ch1 valid.
    rst_pulse();
    in_valid = 4'b0010;
    tick();
    chk("wrap_setup_ch", 32'(out_ch), 32'd1);
    in_valid = 4'b1010;
    tick();
    chk("wrap_first_ch", 32'(out_ch), 32'd3);
    tick();
    chk("wrap_second_ch", 32'(out_ch), 32'd1);
    out_ready = 1'b0;
    tick();

    // Reset while FULL with ptr=2; first grant afterwards is channel 0.
    in_valid = 4'hF; out_ready = 1'b1;
    rst_pulse();
    tick();
    chk("post_rst_out_valid", 32'(out_valid), 32'd1);
    chk("post_rst_out_ch", 32'(out_ch), 32'd0);

`ifdef RR_MUX_PKT_LOCK_EN
    rst_pulse();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0011; in_last = 4'b0000; out_ready = 1'b1;
    tick();
    chk("lock_b1_ch", 32'(out_ch), 32'd1);
    chk("lock_b1_last", 32'(out_last), 32'd0);
    mode = 1'b1;
    tick();
    chk("lock_b2_ch", 32'(out_ch), 32'd1);
    chk("lock_b2_last", 32'(out_last), 32'd0);
    in_last = 4'b0010;
    tick();
    chk("lock_b3_ch", 32'(out_ch), 32'd1);
    chk("lock_b3_last", 32'(out_last), 32'd1);
    in_last = 4'b0000;
    tick();
    chk("lock_next_ch", 32'(out_ch), 32'd0);
    chk("lock_next_last", 32'(out_last), 32'd0);
`endif

    // Randomized traffic, checked every cycle by the model compare.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(15) == 0) mode = 1'($urandom);
      sel       = SW'($urandom);
      in_valid  = N'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(3) != 0);
`ifdef RR_MUX_PKT_LOCK_EN
      in_last   = N'($urandom);
`endif
      if ($urandom_range(499) == 0) rst_pulse();
      tick();
    end

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 Parameter NUM_CH, default 4: number of input channels, 2..16.
REQ-002 Parameter WIDTH, default 8: data width per channel, 1..64.
REQ-003 Port clk  input  1  the single clock; all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port mode  input  1  0 = fixed select via sel; 1 = round-robin arbitration.
REQ-006 Port sel  input  SELW = $clog2(NUM_CH)  channel select, used when mode = 0.
REQ-007 Port in_valid  input  NUM_CH  per-channel data valid.
REQ-008 Port in_data  input  NUM_CH x WIDTH  per-channel data.
REQ-009 Port in_ready  output  NUM_CH  per-channel accept; at most one bit high per cycle.
REQ-010 Port out_valid  output  1  output register holds a beat.
REQ-011 Port out_data  output  WIDTH  registered data of the held beat.
REQ-012 Port out_ch  output  SELW  source channel of the held beat.
REQ-013 Port out_ready  input  1  downstream accept.

Function
REQ-014 Transfer on any port SHALL occur when valid and ready are both high at a rising clk edge.
REQ-015 Output register SHALL be a one-entry stage, EMPTY or FULL; out_valid = FULL.
REQ-016 Stage SHALL be able to load when EMPTY, or when FULL and out_ready = 1 (same-cycle drain and refill, full throughput).
REQ-017 Grant: mode 0 grants channel sel; mode 1 grants the first valid channel at or after ptr, searching upward and wrapping from NUM_CH-1 to 0.
REQ-018 in_ready[g] SHALL be high only for granted channel g, only when in_valid[g] = 1 and the stage can load; other bits low.
REQ-019 Latency SHALL be one cycle: a beat accepted at edge k appears on out_data/out_ch from edge k.
REQ-020 While out_valid = 1 and out_ready = 0, out_data and out_ch SHALL hold stable.
REQ-021 ptr SHALL update to (g+1) mod NUM_CH only on an input transfer in mode 1; unchanged in mode 0.
REQ-022 mode/sel changes SHALL take effect on the next grant decision, never disturbing a held beat.
REQ-023 No valid inputs: no transfer, in_ready = 0, stage drains normally.
REQ-024 sel >= NUM_CH (non-power-of-2 NUM_CH) SHALL grant nothing.

Reset
REQ-025 rst_n low SHALL asynchronously force stage EMPTY, out_valid = 0, out_data = 0, out_ch = 0, ptr = 0; in_ready = 0 while reset asserted.
REQ-026 Reset mid-transfer SHALL drop the held beat; first grant after release starts from channel 0.

Configuration
REQ-027 Macro RR_MUX_PKT_LOCK_EN defined: adds in_last (input, NUM_CH) and out_last (output, 1, reset 0); once a channel transfers a beat with in_last = 0, grant SHALL stay on it, ignoring mode/sel/ptr, until its in_last = 1 beat transfers.
REQ-028 Macro undefined: no in_last/out_last ports; arbitration every beat per REQ-017.

Structure
REQ-029 Package rr_stream_mux_pkg SHALL hold stage-state enum (EMPTY, FULL), mode constants MODE_SEL/MODE_RR, and NUM_CH/WIDTH limits.
REQ-030 Sub-module rr_arbiter (request vector, ptr -> one-hot grant, grant index) SHALL contain the round-robin search.

Verification
REQ-031 mode=0, sel=2, in_data[2]=8'hA5 valid, out_ready=1 -> next cycle out_data=8'hA5, out_ch=2, in_ready=4'b0100.
REQ-032 mode=1, all four valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-033 out_ready=0 for 3 cycles with FULL stage -> out_data/out_ch constant, in_ready=0; release -> drain and refill same cycle.
REQ-034 mode=1, only ch3 and ch1 valid, ptr=2 -> grant ch3 then ch1 (wrap).
REQ-035 rst_n pulsed low while FULL -> out_valid=0 immediately, next grant from ch0.
REQ-036 RR_MUX_PKT_LOCK_EN: ch1 sends 3 beats, last on third, ch0 valid throughout -> out_ch=1,1,1 then 0; out_last=1 on third beat only.
